// File: rtl/req_arb_4_pkg.sv
// rtl/req_arb_4_pkg.sv - shared state encodings and requester count for the 4-way arbiter
package req_arb_4_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_PARK  = 2'd2
  } state_t;

endpackage

// File: rtl/req_arb_4_if.sv
// rtl/req_arb_4_if.sv - request/grant bundle between requesters and the arbiter
interface req_arb_4_if;
  import req_arb_4_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            gnt_v;
  logic            tmo;

  modport master (output req, input gnt, gnt_id, gnt_v, tmo);
  modport slave  (input req, output gnt, gnt_id, gnt_v, tmo);

endinterface

// File: rtl/req_arb_4_pick.sv
// rtl/req_arb_4_pick.sv - combinational winner select; ROUND_ROBIN_EN selects rotating search
//   (upward from start) instead of fixed downward priority from start.
module arb_pick_4
  import req_arb_4_pkg::*;
(
  input  logic [NREQ-1:0] eligible,
  input  logic [1:0]      start,
  output logic [1:0]      id,
  output logic            valid
);

  logic [1:0] idx;

  // Scan from the lowest-precedence offset up so the start position overwrites last.
  always_comb begin
    id    = 2'd0;
    valid = 1'b0;
    idx   = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ROUND_ROBIN_EN
      idx = start + 2'(k);
`else
      idx = start - 2'(k);
`endif
      if (eligible[idx]) begin
        id    = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arb_4.sv
// rtl/req_arb_4.sv - 4-requester arbiter with registered grants, hold timeout and mask;
//   ROUND_ROBIN_EN enables rotating priority, otherwise highest index wins.
module req_arb_4
  import req_arb_4_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  req_arb_4_if.slave  bus
);

  localparam int            CW       = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

  state_t          state, state_n;
  logic [CW-1:0]   hold_cnt, hold_n;
  logic [NREQ-1:0] mask, mask_n;
  logic [1:0]      last_id, last_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic [1:0]      gnt_id_q, gnt_id_n;
  logic            tmo_q, tmo_n;

  logic [NREQ-1:0] eligible;
  logic [1:0]      pick_start;
  logic [1:0]      pick_id;
  logic            pick_v;

  assign eligible = bus.req & ~mask;

`ifdef ROUND_ROBIN_EN
  assign pick_start = last_id + 2'd1;
`else
  assign pick_start = 2'd3;
`endif

  arb_pick_4 u_pick (
    .eligible (eligible),
    .start    (pick_start),
    .id       (pick_id),
    .valid    (pick_v)
  );

  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    mask_n   = mask & bus.req;
    last_n   = last_id;
    gnt_n    = '0;
    gnt_id_n = gnt_id_q;
    tmo_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_v) begin
          state_n         = ST_GRANT;
          gnt_n[pick_id]  = 1'b1;
          gnt_id_n        = pick_id;
          last_n          = pick_id;
          hold_n          = (HOLD_MAX != 0) ? CW'(1) : '0;
        end
      end
      ST_GRANT: begin
        // A release in the same cycle as expiry wins: no tmo, no mask.
        if (!bus.req[gnt_id_q]) begin
          state_n = ST_PARK;
        end else if ((HOLD_MAX != 0) && (hold_cnt == HOLD_LIM)) begin
          state_n          = ST_PARK;
          tmo_n            = 1'b1;
          mask_n[gnt_id_q] = 1'b1;
        end else begin
          gnt_n = gnt_q;
          if ((HOLD_MAX != 0) && (hold_cnt != HOLD_LIM))
            hold_n = hold_cnt + CW'(1);
        end
      end
      ST_PARK: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      mask     <= '0;
      last_id  <= 2'd3;
      gnt_q    <= '0;
      gnt_id_q <= 2'd0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      mask     <= mask_n;
      last_id  <= last_n;
      gnt_q    <= gnt_n;
      gnt_id_q <= gnt_id_n;
      tmo_q    <= tmo_n;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.gnt_v  = |gnt_q;
  assign bus.tmo    = tmo_q;

endmodule
